// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings for the data-memory path: access-size funct3 codes,
// LSU state type and LSU response error codes.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  localparam logic [1:0] LSU_ERR_NONE     = 2'd0;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'd1;
  localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, replicated store data, alignment and
// legality flags, and sign/zero extension of the addressed load lane.
module lsu_align
  import riscv_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic        illegal,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    be        = 4'h0;
    wdata_rep = 32'h0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    if (store) begin
      case (funct3)
        F3_SB: begin
          be        = 4'b0001 << offset;
          wdata_rep = {4{wdata[7:0]}};
        end
        F3_SH: begin
          be        = 4'b0011 << offset;
          wdata_rep = {2{wdata[15:0]}};
          misalign  = offset[0];
        end
        F3_SW: begin
          be        = 4'hF;
          wdata_rep = wdata;
          misalign  = (offset != 2'd0);
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      be = 4'hF;
      case (funct3)
        F3_LB, F3_LBU: misalign = 1'b0;
        F3_LH, F3_LHU: misalign = offset[0];
        F3_LW:         misalign = (offset != 2'd0);
        default:       illegal  = 1'b1;
      endcase
    end
  end

  always_comb begin
    byte_lane = rdata[7:0];
    case (offset)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
  end

  assign half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    rdata_ext = rdata;
    case (funct3)
      F3_LB:   rdata_ext = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU:  rdata_ext = {24'h0, byte_lane};
      F3_LH:   rdata_ext = {{16{half_lane[15]}}, half_lane};
      F3_LHU:  rdata_ext = {16'h0, half_lane};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store per handshake, drives a
// req/gnt/rvalid port with a watchdog, and returns a one-cycle response.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t      state;
  logic            store_q;
  logic [2:0]      funct3_q;
  logic [1:0]      offset_q;
  logic [WD_W-1:0] watchdog;

  logic            in_idle;
  logic            timeout;
  logic            a_store;
  logic [2:0]      a_funct3;
  logic [1:0]      a_offset;
  logic [3:0]      a_be;
  logic [31:0]     a_wdata;
  logic [31:0]     a_rdata;
  logic            a_misalign;
  logic            a_illegal;

  assign in_idle   = (state == IDLE);
  assign req_ready = in_idle && !rst;
  // The watchdog value equals the number of busy cycles already completed.
  assign timeout   = ((state == REQ) || (state == WAIT)) && (watchdog == WD_LAST);

  // In IDLE the lane logic decodes the incoming request; afterwards it
  // works on the latched access so load extraction sees the right lane.
  assign a_store  = in_idle ? req_store      : store_q;
  assign a_funct3 = in_idle ? req_funct3     : funct3_q;
  assign a_offset = in_idle ? req_addr[1:0]  : offset_q;

  lsu_align u_align (
    .store     (a_store),
    .funct3    (a_funct3),
    .offset    (a_offset),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (a_be),
    .wdata_rep (a_wdata),
    .misalign  (a_misalign),
    .illegal   (a_illegal),
    .rdata_ext (a_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      store_q    <= 1'b0;
      funct3_q   <= 3'h0;
      offset_q   <= 2'h0;
      watchdog   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'h0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= LSU_ERR_NONE;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          watchdog <= '0;
          if (req_valid) begin
            store_q    <= req_store;
            funct3_q   <= req_funct3;
            offset_q   <= req_addr[1:0];
            resp_rdata <= 32'h0;
            if (a_illegal || a_misalign) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= a_illegal ? LSU_ERR_ILLEGAL : LSU_ERR_MISALIGN;
            end else begin
              state     <= REQ;
              resp_err  <= LSU_ERR_NONE;
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_be    <= a_be;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= a_wdata;
            end
          end
        end

        REQ: begin
          watchdog <= watchdog + WD_W'(1);
          if (timeout) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= LSU_ERR_TIMEOUT;
            resp_rdata <= 32'h0;
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
            if (store_q) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          watchdog <= watchdog + WD_W'(1);
          if (timeout) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= LSU_ERR_TIMEOUT;
            resp_rdata <= 32'h0;
          end else if (mem_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= a_rdata;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
